// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch port (if_*)
// and the load/store port (d_*). Data accesses normally win. After
// STARVE_LIMIT back-to-back data grants with a fetch waiting, the fetch is
// forced through. Only one memory transaction is outstanding at a time. The
// memory-side request is registered, and the response is routed back to
// whichever requester owns the transaction.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   if_req/if_addr                     fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata          fetch grant pulse, response pulse, data
//   d_req/d_we/d_addr/d_wdata/d_be     load/store request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata             data grant pulse, response pulse, data
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be                   registered memory request
//   mem_ready                          memory accepts mem_req this cycle
//   mem_rvalid/mem_rdata               memory response

module mem_port_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  // fetch port
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  // load/store port
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  // memory port
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BE_W  = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_D  = 1'b0,
    OWN_IF = 1'b1
  } owner_e;

  state_e            state_q,      state_d;
  owner_e            owner_q,      owner_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              mem_req_q,    mem_req_d;
  logic              mem_we_q,     mem_we_d;
  logic [XLEN-1:0]   mem_addr_q,   mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q,  mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q,     mem_be_d;

  logic grant_if;
  logic grant_d;
  logic done;

  // Grant selection in IDLE. The counter saturates at LIMIT, so anything
  // not below LIMIT means a fetch has waited long enough. Grants are held
  // off while reset is asserted so the strobes read 0 during reset.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (d_req && (!if_req || (starve_cnt_q < LIMIT))) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  // Completion: a normal response in RESP, or a response that arrives
  // together with the accept while still in REQ.
  always_comb begin
    done = 1'b0;
    if (state_q == RESP) begin
      done = mem_rvalid;
    end else if (state_q == REQ) begin
      done = mem_ready && mem_rvalid;
    end
  end

  // Next-state, request capture and starvation counter.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;

    case (state_q)
      IDLE: begin
        // Counter only tracks runs of data grants while a fetch is waiting.
        if (!if_req || grant_if) begin
          starve_cnt_d = '0;
        end else if (grant_d && (starve_cnt_q < LIMIT)) begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        if (grant_d) begin
          owner_d     = OWN_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          state_d     = REQ;
        end else if (grant_if) begin
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = BE_W'(4'hF);
          state_d     = REQ;
        end
      end

      REQ: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = mem_rvalid ? IDLE : RESP;
        end
      end

      RESP: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end

      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_D;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
    end
  end

  // Requester-side strobes and response routing.
  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = done && (owner_q == OWN_IF);
  assign d_rvalid  = done && (owner_q == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  // Memory-side request.
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule
